// File: rtl/multicycle_adder_if.sv
// Operand/result bundle for the segment-serial adder.
// The master drives the request; the slave returns the registered result and its status.
interface multicycle_adder_if #(
    parameter int WIDTH = 16
);
    logic             Start;
    logic             Sub;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] S;
    logic             C_out;
    logic             Overflow;
    logic             Busy;
    logic             Done;

    modport master (
        output Start, Sub, A, B,
        input  S, C_out, Overflow, Busy, Done
    );

    modport slave (
        input  Start, Sub, A, B,
        output S, C_out, Overflow, Busy, Done
    );
endinterface

// File: rtl/multicycle_adder.sv
// Adds or subtracts two WIDTH-bit operands SEG bits per clock.
// The result, carry and overflow appear on S only once the whole word has been summed.
module multicycle_adder #(
    parameter int WIDTH = 16,
    parameter int SEG   = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    multicycle_adder_if.slave bus
);
    localparam int NSEG = WIDTH / SEG;
    localparam int CW   = (NSEG > 1) ? $clog2(NSEG) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic [WIDTH-1:0] s_r;
    logic [CW-1:0]    cnt_r;
    logic             carry_r;
    logic             c_out_r;
    logic             overflow_r;
    logic             busy_r;
    logic             done_r;

    logic [SEG:0]     seg_sum_s;
    logic [WIDTH-1:0] next_sum_s;
    logic             last_s;

    // Current segment sum and the partial word it produces.
    always_comb begin
        seg_sum_s  = {1'b0, a_r[cnt_r*SEG +: SEG]} + {1'b0, b_r[cnt_r*SEG +: SEG]}
                   + {{SEG{1'b0}}, carry_r};
        next_sum_s = sum_r;
        next_sum_s[cnt_r*SEG +: SEG] = seg_sum_s[SEG-1:0];
        last_s     = (cnt_r == CW'(NSEG - 1));
    end

    // Control FSM with datapath registers; B is pre-inverted and carry seeded so Sub becomes A + ~B + 1.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r    <= IDLE;
            a_r        <= '0;
            b_r        <= '0;
            sum_r      <= '0;
            s_r        <= '0;
            cnt_r      <= '0;
            carry_r    <= 1'b0;
            c_out_r    <= 1'b0;
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.Start) begin
                        a_r     <= bus.A;
                        b_r     <= bus.B ^ {WIDTH{bus.Sub}};
                        carry_r <= bus.Sub;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end
                end
                RUN: begin
                    sum_r   <= next_sum_s;
                    carry_r <= seg_sum_s[SEG];
                    cnt_r   <= cnt_r + CW'(1);
                    if (last_s) begin
                        s_r        <= next_sum_s;
                        c_out_r    <= seg_sum_s[SEG];
                        // Carry into the MSB is recovered from the MSB's own sum bit.
                        overflow_r <= a_r[WIDTH-1] ^ b_r[WIDTH-1] ^ next_sum_s[WIDTH-1]
                                    ^ seg_sum_s[SEG];
                        done_r     <= 1'b1;
                        state_r    <= DONE;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.S        = s_r;
    assign bus.C_out    = c_out_r;
    assign bus.Overflow = overflow_r;
    assign bus.Busy     = busy_r;
    assign bus.Done     = done_r;
endmodule

// File: tb/tb_multicycle_adder.sv
// Self-checking bench: three adder configurations (16/4, 8/8, 32/1) checked against
// a plain-arithmetic reference model, plus directed boundary, ignore and reset scenarios.
module tb_multicycle_adder;
    logic Clk = 1'b0;
    logic Reset;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 Clk = ~Clk;

    multicycle_adder_if #(.WIDTH(16)) bus0 ();
    multicycle_adder_if #(.WIDTH(8))  bus1 ();
    multicycle_adder_if #(.WIDTH(32)) bus2 ();

    multicycle_adder #(.WIDTH(16), .SEG(4)) dut0 (.Clk(Clk), .Reset(Reset), .bus(bus0));
    multicycle_adder #(.WIDTH(8),  .SEG(8)) dut1 (.Clk(Clk), .Reset(Reset), .bus(bus1));
    multicycle_adder #(.WIDTH(32), .SEG(1)) dut2 (.Clk(Clk), .Reset(Reset), .bus(bus2));

    function automatic int width_of(int idx);
        return (idx == 0) ? 16 : (idx == 1) ? 8 : 32;
    endfunction

    function automatic int nseg_of(int idx);
        return (idx == 0) ? 4 : (idx == 1) ? 1 : 32;
    endfunction

    // Reference: unsigned sum/difference modulo 2^w, carry = no-borrow for Sub,
    // overflow = true signed result outside the w-bit signed range.
    function automatic void ref_model(input int w, input bit sub, input logic [31:0] a,
                                      input logic [31:0] b, output logic [31:0] s,
                                      output logic c, output logic ov);
        longint md, ua, ub, sa, sb, r;
        md = longint'(1) << w;
        ua = longint'({32'h0, a}) & (md - 1);
        ub = longint'({32'h0, b}) & (md - 1);
        sa = (ua >= md / 2) ? ua - md : ua;
        sb = (ub >= md / 2) ? ub - md : ub;
        if (!sub) begin
            c = ((ua + ub) >= md);
            s = 32'((ua + ub) % md);
            r = sa + sb;
        end else begin
            c = (ua >= ub);
            s = 32'((ua - ub + md) % md);
            r = sa - sb;
        end
        ov = (r < -(md / 2)) || (r >= md / 2);
    endfunction

    task automatic drive(input int idx, input bit start, input bit sub,
                         input logic [31:0] a, input logic [31:0] b);
        case (idx)
            0: begin bus0.Start = start; bus0.Sub = sub; bus0.A = a[15:0]; bus0.B = b[15:0]; end
            1: begin bus1.Start = start; bus1.Sub = sub; bus1.A = a[7:0];  bus1.B = b[7:0];  end
            default: begin bus2.Start = start; bus2.Sub = sub; bus2.A = a; bus2.B = b; end
        endcase
    endtask

    task automatic sample(input int idx, output logic [31:0] s, output logic c,
                          output logic ov, output logic busy, output logic done);
        case (idx)
            0: begin s = {16'h0, bus0.S}; c = bus0.C_out; ov = bus0.Overflow; busy = bus0.Busy; done = bus0.Done; end
            1: begin s = {24'h0, bus1.S}; c = bus1.C_out; ov = bus1.Overflow; busy = bus1.Busy; done = bus1.Done; end
            default: begin s = bus2.S; c = bus2.C_out; ov = bus2.Overflow; busy = bus2.Busy; done = bus2.Done; end
        endcase
    endtask

    // One Start pulse, operands scrambled right after acceptance; measures latency and Busy span.
    task automatic run_op(input int idx, input bit sub, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] s, output logic c, output logic ov,
                          output int lat, output int busy_cnt,
                          output logic [31:0] s_after, output logic done_after);
        logic [31:0] ts;
        logic tc, tov, tbusy, tdone;
        @(negedge Clk);
        drive(idx, 1'b1, sub, a, b);
        @(posedge Clk); #1;
        drive(idx, 1'b0, ~sub, ~a, ~b);
        sample(idx, ts, tc, tov, tbusy, tdone);
        busy_cnt = tbusy ? 1 : 0;
        lat = 0;
        while (lat < 200) begin
            @(posedge Clk); #1;
            lat++;
            sample(idx, ts, tc, tov, tbusy, tdone);
            if (tbusy) busy_cnt++;
            if (tdone) break;
        end
        s = ts; c = tc; ov = tov;
        @(posedge Clk); #1;
        sample(idx, ts, tc, tov, tbusy, tdone);
        s_after = ts;
        done_after = tdone;
    endtask

    task automatic test_reset();
        logic [31:0] s;
        logic c, ov, busy, done;
        Reset = 1'b1;
        for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 32'h0, 32'h0);
        #2;
        for (int i = 0; i < 3; i++) begin
            sample(i, s, c, ov, busy, done);
            n_cmp++;
            if ({s, c, ov, busy, done} !== 36'h0) begin
                n_bad++;
                $display("FAIL reset_state idx=%0d got S=%h C=%b OV=%b Busy=%b Done=%b want all 0",
                         i, s, c, ov, busy, done);
            end
        end
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] va [5] = '{32'h1234, 32'hFFFF, 32'h7FFF, 32'h0005, 32'h8000};
        logic [31:0] vb [5] = '{32'h4321, 32'h0001, 32'h0001, 32'h0007, 32'h0001};
        logic [31:0] vs [5] = '{32'h5555, 32'h0000, 32'h8000, 32'hFFFE, 32'h7FFF};
        bit vsub [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        bit vc   [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        bit vov  [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [31:0] s, s_after;
        logic c, ov, done_after;
        int lat, busy_cnt;
        for (int i = 0; i < 5; i++) begin
            run_op(0, vsub[i], va[i], vb[i], s, c, ov, lat, busy_cnt, s_after, done_after);
            n_cmp++;
            if (s !== vs[i] || c !== vc[i] || ov !== vov[i]) begin
                n_bad++;
                $display("FAIL directed_result #%0d got S=%h C=%b OV=%b want S=%h C=%b OV=%b",
                         i, s, c, ov, vs[i], vc[i], vov[i]);
            end
            n_cmp++;
            if (lat !== 4 || busy_cnt !== 5) begin
                n_bad++;
                $display("FAIL directed_timing #%0d got lat=%0d busy=%0d want lat=4 busy=5",
                         i, lat, busy_cnt);
            end
            n_cmp++;
            if (done_after !== 1'b0 || s_after !== vs[i]) begin
                n_bad++;
                $display("FAIL directed_hold #%0d got Done=%b S=%h want Done=0 S=%h",
                         i, done_after, s_after, vs[i]);
            end
        end
    endtask

    task automatic test_ignore_and_back_to_back();
        logic [31:0] s;
        logic c, ov, busy, done;
        int dones = 0;
        @(negedge Clk);
        drive(0, 1'b1, 1'b0, 32'h0001, 32'h0001);
        @(posedge Clk); #1;
        drive(0, 1'b1, 1'b0, 32'hFFFF, 32'hFFFF);
        for (int i = 1; i <= 12; i++) begin
            @(posedge Clk); #1;
            if (i == 6) drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
            sample(0, s, c, ov, busy, done);
            if (done) dones++;
            if (i == 4) begin
                n_cmp++;
                if (done !== 1'b1 || s !== 32'h0002) begin
                    n_bad++;
                    $display("FAIL ignore_first got Done=%b S=%h want Done=1 S=0002", done, s);
                end
            end
            if (i == 5) begin
                n_cmp++;
                if (busy !== 1'b0 || done !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_idle_gap got Busy=%b Done=%b want 0 0", busy, done);
                end
            end
            if (i == 6) begin
                n_cmp++;
                if (busy !== 1'b1 || s !== 32'h0002) begin
                    n_bad++;
                    $display("FAIL b2b_accept got Busy=%b S=%h want Busy=1 S=0002", busy, s);
                end
            end
            if (i == 10) begin
                n_cmp++;
                if (done !== 1'b1 || s !== 32'hFFFE || c !== 1'b1 || ov !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_second got Done=%b S=%h C=%b OV=%b want 1 FFFE 1 0",
                             done, s, c, ov);
                end
            end
        end
        n_cmp++;
        if (dones !== 2) begin
            n_bad++;
            $display("FAIL ignore_done_count got %0d want 2", dones);
        end
    endtask

    task automatic test_reset_midrun();
        logic [31:0] s, s_after;
        logic c, ov, busy, done, done_after;
        int lat, busy_cnt, dones = 0;
        @(negedge Clk);
        drive(0, 1'b1, 1'b0, 32'h00AB, 32'h00CD);
        @(posedge Clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge Clk);
        @(posedge Clk); #2;
        Reset = 1'b1;
        #1;
        sample(0, s, c, ov, busy, done);
        n_cmp++;
        if ({s, c, ov, busy, done} !== 36'h0) begin
            n_bad++;
            $display("FAIL reset_midrun got S=%h C=%b OV=%b Busy=%b Done=%b want all 0",
                     s, c, ov, busy, done);
        end
        @(negedge Clk);
        Reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge Clk); #1;
            sample(0, s, c, ov, busy, done);
            if (done || busy || s !== 32'h0) dones++;
        end
        n_cmp++;
        if (dones !== 0) begin
            n_bad++;
            $display("FAIL reset_abort got %0d active cycles want 0", dones);
        end
        run_op(0, 1'b0, 32'h00FF, 32'h0001, s, c, ov, lat, busy_cnt, s_after, done_after);
        n_cmp++;
        if (s !== 32'h0100 || c !== 1'b0 || ov !== 1'b0 || lat !== 4) begin
            n_bad++;
            $display("FAIL reset_recover got S=%h C=%b OV=%b lat=%0d want 0100 0 0 4",
                     s, c, ov, lat);
        end
    endtask

    task automatic test_random();
        logic [31:0] s, s_after, es, a, b;
        logic c, ov, done_after, ec, eov;
        int lat, busy_cnt, w;
        bit sub;
        for (int idx = 0; idx < 3; idx++) begin
            w = width_of(idx);
            for (int k = 0; k < 24; k++) begin
                case (k)
                    0: begin sub = 1'b0; a = 32'hFFFFFFFF; b = 32'h1; end
                    1: begin sub = 1'b0; a = 32'hFFFFFFFF >> (33 - w); b = 32'h1; end
                    2: begin sub = 1'b1; a = 32'h5; b = 32'h7; end
                    3: begin sub = 1'b1; a = 32'h1 << (w - 1); b = 32'h1; end
                    default: begin sub = 1'($urandom); a = $urandom; b = $urandom; end
                endcase
                ref_model(w, sub, a, b, es, ec, eov);
                run_op(idx, sub, a, b, s, c, ov, lat, busy_cnt, s_after, done_after);
                n_cmp++;
                if (s !== es || c !== ec || ov !== eov) begin
                    n_bad++;
                    $display("FAIL rand_result idx=%0d k=%0d sub=%b a=%h b=%h got S=%h C=%b OV=%b want S=%h C=%b OV=%b",
                             idx, k, sub, a, b, s, c, ov, es, ec, eov);
                end
                n_cmp++;
                if (lat !== nseg_of(idx) || busy_cnt !== nseg_of(idx) + 1 || done_after !== 1'b0) begin
                    n_bad++;
                    $display("FAIL rand_timing idx=%0d k=%0d got lat=%0d busy=%0d done_after=%b want lat=%0d busy=%0d done_after=0",
                             idx, k, lat, busy_cnt, done_after, nseg_of(idx), nseg_of(idx) + 1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_ignore_and_back_to_back();
        test_reset_midrun();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
